// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helpers for the program-counter generator.
// Contents: FSM state encoding, next-PC select codes, default parameters,
//           and the branch-target alignment predicate.
package pc_gen_pkg;

  // Default geometry of the PC.
  localparam int          PC_XLEN_DEF   = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          IALIGN_DEF    = 4;

  // Fetch FSM: BOOT is a single settling cycle after reset, RUN issues
  // requests, HALT parks the PC until a wake or trap.
  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_HALT = 2'd2
  } pcg_state_t;

  // Which source feeds the PC register next cycle, highest priority first.
  typedef enum logic [2:0] {
    SEL_TRAP     = 3'd0,
    SEL_MRET     = 3'd1,
    SEL_BRANCH   = 3'd2,
    SEL_MISALIGN = 3'd3,
    SEL_SEQ      = 3'd4,
    SEL_HOLD     = 3'd5
  } pc_sel_t;

  // A target is misaligned when any address bit below IALIGN is set.
  // Only the low two bits matter because IALIGN is 2 or 4.
  function automatic logic is_misaligned(input logic [1:0] low, input int ialign);
    if (ialign == 2)
      return low[0];
    else
      return (low != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC priority select and branch alignment check.
// Ports: pc (current PC), enables for trap / other redirects / sequential
//        advance, redirect inputs; outputs pc_next and a misalign strobe.
module pc_next_mux
  import pc_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic            trap_en,
  input  logic            redir_en,
  input  logic            seq_en,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret_take,
  input  logic [XLEN-1:0] mepc,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign
);

  localparam logic [XLEN-1:0] INC        = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(IALIGN - 1);

  pc_sel_t sel;
  logic    tgt_misaligned;

  // The mtvec mode bits never reach the PC.
  logic unused_trap_mode;
  assign unused_trap_mode = ^trap_vec[1:0];

  assign tgt_misaligned = is_misaligned(branch_target[1:0], IALIGN);

  // Priority decode. Trap is the only redirect honoured while halted, so it
  // has its own enable; mret and branch only act while fetching.
  always_comb begin
    sel = SEL_HOLD;
    if (trap_en && trap_take)
      sel = SEL_TRAP;
    else if (redir_en && mret_take)
      sel = SEL_MRET;
    else if (redir_en && branch_take)
      sel = tgt_misaligned ? SEL_MISALIGN : SEL_BRANCH;
    else if (seq_en)
      sel = SEL_SEQ;
  end

  always_comb begin
    pc_next  = pc;
    misalign = 1'b0;
    case (sel)
      SEL_TRAP:     pc_next = {trap_vec[XLEN-1:2], 2'b00};
      SEL_MRET:     pc_next = mepc & ALIGN_MASK;
      SEL_BRANCH:   pc_next = branch_target;
      // A bad target leaves the PC alone and is reported to the trap logic.
      SEL_MISALIGN: misalign = 1'b1;
      // Wraps modulo 2^XLEN silently.
      SEL_SEQ:      pc_next = pc + INC;
      default:      pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with valid/ready fetch handshake,
//         prioritised redirects (trap > mret > branch), WFI halt and
//         misaligned-target flagging.
// Ports: clk, rst (sync, active-high); pc_out/pc_valid/pc_ready fetch
//        handshake; branch/mret/trap redirect inputs; halt_req/wake;
//        misalign_err one-cycle pulse.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               XLEN      = PC_XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int               IALIGN    = IALIGN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_target,
  input  logic            mret_take,
  input  logic [XLEN-1:0] mepc,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            wake,
  output logic            misalign_err
);

  pcg_state_t      state;
  logic [XLEN-1:0] pc_next;
  logic            misalign;
  logic            trap_en;
  logic            redir_en;
  logic            seq_en;

  // Redirects are dropped during BOOT. While halted only a trap can move
  // the PC.
  assign trap_en  = (state != PCG_BOOT);
  assign redir_en = (state == PCG_RUN);
  // halt_req freezes the sequential advance so that fetch resumes at the
  // same PC after wake.
  assign seq_en   = pc_valid && pc_ready && !halt_req;

  pc_next_mux #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next (
    .pc            (pc_out),
    .trap_en       (trap_en),
    .redir_en      (redir_en),
    .seq_en        (seq_en),
    .trap_take     (trap_take),
    .trap_vec      (trap_vec),
    .mret_take     (mret_take),
    .mepc          (mepc),
    .branch_take   (branch_take),
    .branch_target (branch_target),
    .pc_next       (pc_next),
    .misalign      (misalign)
  );

  // PC register, FSM and registered outputs in one block; pc_valid mirrors
  // "next state is RUN" so it is glitch-free and only changes on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PCG_BOOT;
      pc_out       <= RESET_VEC;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        PCG_BOOT: begin
          state        <= PCG_RUN;
          pc_valid     <= 1'b1;
          misalign_err <= 1'b0;
        end
        PCG_RUN: begin
          pc_out       <= pc_next;
          misalign_err <= misalign;
          // A redirect in the same cycle is still applied above.
          if (halt_req) begin
            state    <= PCG_HALT;
            pc_valid <= 1'b0;
          end
        end
        PCG_HALT: begin
          misalign_err <= 1'b0;
          // pc_next is either the trap vector or the held PC here.
          pc_out       <= pc_next;
          if (trap_take || wake) begin
            state    <= PCG_RUN;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state        <= PCG_BOOT;
          pc_valid     <= 1'b0;
          misalign_err <= 1'b0;
        end
      endcase
    end
  end

endmodule
